axi_lite_cmd_master: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI-Lite write or read transactions and returns one response per command. It sits directly upstream of the AXI-Lite register slave: its `M_AXI_LITE_*` ports connect one-to-one to the slave's `S_AXI_LITE_*` ports. It is the bridge from internal sequencers and debug logic into the register file.

---
 rtl/axi_lite_pkg.sv | 39 +++
 rtl/axi_lite_cmd_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite types for the command master
//
// Purpose: response codes, command-master FSM states and default-width
// command/response records shared by the AXI-Lite command master and its users.
package axi_lite_pkg;

  localparam int AXI_LITE_ADDR_W = 4;
  localparam int AXI_LITE_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WR_B  = 3'd2,
    RD_AR = 3'd3,
    RD_R  = 3'd4,
    RSP   = 3'd5
  } cmd_mst_state_e;

  typedef struct packed {
    logic                         write;
    logic [AXI_LITE_ADDR_W-1:0]   addr;
    logic [AXI_LITE_DATA_W-1:0]   wdata;
    logic [AXI_LITE_DATA_W/8-1:0] wstrb;
  } axi_lite_cmd_t;

  typedef struct packed {
    logic [AXI_LITE_DATA_W-1:0] rdata;
    axi_resp_e                  resp;
    logic                       timeout;
  } axi_lite_rsp_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI-Lite master driven by a command stream
//
// Purpose: accepts one command (cmd_*), runs the matching AXI-Lite write or
// read, and returns one response (rsp_*) before accepting the next command.
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   cmd_*                 command stream in (valid/ready)
//   rsp_*                 response stream out (valid/ready)
//   M_AXI_LITE_*          AXI-Lite master (AW, W, B, AR, R channels)
// Optional feature: define AXI_LITE_CMD_MASTER_TIMEOUT_EN to build the
// watchdog that aborts a stalled transaction after TIMEOUT_CYCLES cycles.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_awaddr,
  output logic [2:0]              M_AXI_LITE_awprot,
  output logic                    M_AXI_LITE_awvalid,
  input  logic                    M_AXI_LITE_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_LITE_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_LITE_wstrb,
  output logic                    M_AXI_LITE_wvalid,
  input  logic                    M_AXI_LITE_wready,
  input  logic [1:0]              M_AXI_LITE_bresp,
  input  logic                    M_AXI_LITE_bvalid,
  output logic                    M_AXI_LITE_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_araddr,
  output logic [2:0]              M_AXI_LITE_arprot,
  output logic                    M_AXI_LITE_arvalid,
  input  logic                    M_AXI_LITE_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_LITE_rdata,
  input  logic [1:0]              M_AXI_LITE_rresp,
  input  logic                    M_AXI_LITE_rvalid,
  output logic                    M_AXI_LITE_rready
);

  cmd_mst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  axi_resp_e               rsp_resp_q, rsp_resp_d;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`else
  // TIMEOUT_CYCLES only shapes the watchdog; this empty block keeps the
  // parameter referenced so both builds share one parameter list.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    tmo_d         = '0;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // A dropped valid doubles as that channel's done flag.
        if (M_AXI_LITE_awready) awvalid_d = 1'b0;
        if (M_AXI_LITE_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (M_AXI_LITE_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = axi_resp_e'(M_AXI_LITE_bresp);
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (M_AXI_LITE_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (M_AXI_LITE_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = M_AXI_LITE_rdata;
          rsp_resp_d  = axi_resp_e'(M_AXI_LITE_rresp);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    // Progress on the current edge wins over the watchdog; the count only
    // runs while the FSM sits in the same busy state.
    if ((state_q inside {WR, WR_B, RD_AR, RD_R}) && (state_d == state_q)) begin
      if (tmo_q == TMO_LAST) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = SLVERR;
        rsp_timeout_d = 1'b1;
        state_d       = RSP;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tmo_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready          = (state_q == IDLE);
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;
  assign M_AXI_LITE_awaddr  = addr_q;
  assign M_AXI_LITE_awprot  = 3'b000;
  assign M_AXI_LITE_awvalid = awvalid_q;
  assign M_AXI_LITE_wdata   = wdata_q;
  assign M_AXI_LITE_wstrb   = wstrb_q;
  assign M_AXI_LITE_wvalid  = wvalid_q;
  assign M_AXI_LITE_bready  = bready_q;
  assign M_AXI_LITE_araddr  = addr_q;
  assign M_AXI_LITE_arprot  = 3'b000;
  assign M_AXI_LITE_arvalid = arvalid_q;
  assign M_AXI_LITE_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - self-checking bench for axi_lite_cmd_master
module tb_axi_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  axi_lite_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awprot(awprot),
    .M_AXI_LITE_awvalid(awvalid), .M_AXI_LITE_awready(awready),
    .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb),
    .M_AXI_LITE_wvalid(wvalid), .M_AXI_LITE_wready(wready),
    .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid), .M_AXI_LITE_bready(bready),
    .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arprot(arprot),
    .M_AXI_LITE_arvalid(arvalid), .M_AXI_LITE_arready(arready),
    .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp),
    .M_AXI_LITE_rvalid(rvalid), .M_AXI_LITE_rready(rready)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Slave response code is a fixed function of the word address, so the
  // reference model knows what must be passed through.
  function automatic logic [1:0] resp_of(input logic [3:0] a);
    case (a[3:2])
      2'd0:    resp_of = 2'd1;
      2'd1:    resp_of = 2'd0;
      default: resp_of = a[3:2];
    endcase
  endfunction

  // Reference model: expected register contents after each completed write.
  logic [31:0] mem_model [4];
  // Slave environment state.
  logic [31:0] mem_slv [4];
  int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int  aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit  never_arready = 0, tmo_mode = 0;
  bit  aw_got = 0, w_got = 0, ar_got = 0;
  bit  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  bit  p_awv = 0, p_wv = 0, p_arv = 0;
  logic [3:0]  cap_awaddr = '0, cap_araddr = '0, exp_addr = '0, exp_wstrb = '0;
  logic [31:0] cap_wdata = '0, exp_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  int  viol = 0, b_cnt = 0, n_wr = 0, last_lat = 0;
  bit  awv1, wv1, arv1, awv2, wv2;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0;
        rvalid = 0; rdata = '0; rresp = '0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        if (!tmo_mode) begin
          if (p_awv && !aw_hs && !awvalid) viol++;
          if (p_wv && !w_hs && !wvalid) viol++;
          if (p_arv && !ar_hs && !arvalid) viol++;
        end
        if (aw_hs) begin aw_got = 1; aw_wait = 0; end
        if (w_hs)  begin w_got = 1; w_wait = 0; end
        if (b_hs)  begin bvalid = 0; b_cnt++; end
        if (ar_hs) begin ar_got = 1; ar_wait = 0; end
        if (r_hs)  rvalid = 0;
        if (aw_got && w_got && !bvalid) begin
          if (b_wait >= b_dly) begin
            for (int b = 0; b < 4; b++)
              if (cap_wstrb[b]) mem_slv[cap_awaddr[3:2]][8*b +: 8] = cap_wdata[8*b +: 8];
            bvalid = 1; bresp = resp_of(cap_awaddr);
            aw_got = 0; w_got = 0; b_wait = 0;
          end else b_wait++;
        end
        if (ar_got && !rvalid) begin
          if (r_wait >= r_dly) begin
            rvalid = 1; rdata = mem_slv[cap_araddr[3:2]]; rresp = resp_of(cap_araddr);
            ar_got = 0; r_wait = 0;
          end else r_wait++;
        end
        awready = awvalid && !aw_got && (aw_wait >= aw_dly);
        if (awvalid && !awready) aw_wait++;
        wready = wvalid && !w_got && (w_wait >= w_dly);
        if (wvalid && !wready) w_wait++;
        arready = arvalid && !never_arready && !ar_got && (ar_wait >= ar_dly);
        if (arvalid && !arready) ar_wait++;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        b_hs  = bvalid && bready;
        r_hs  = rvalid && rready;
        if (aw_hs) begin
          cap_awaddr = awaddr;
          check("awaddr", awaddr, exp_addr);
          check("awprot", awprot, 3'b000);
        end
        if (w_hs) begin
          cap_wdata = wdata; cap_wstrb = wstrb;
          check("wdata", wdata, exp_wdata);
          check("wstrb", wstrb, exp_wstrb);
        end
        if (ar_hs) begin
          cap_araddr = araddr;
          check("araddr", araddr, exp_addr);
          check("arprot", arprot, 3'b000);
        end
        p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
      end
    end
  end

  // Issue one command and check its response; called at a negedge.
  task automatic run_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold);
    logic [31:0] er;
    logic [1:0]  eresp;
    int n;
    exp_addr = a; exp_wdata = d; exp_wstrb = s;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    check("cmd_accept", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid = 0;
    awv1 = awvalid; wv1 = wvalid; arv1 = arvalid;
    @(negedge aclk);
    awv2 = awvalid; wv2 = wvalid;
    n = 2;
    while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
    last_lat = n;
    er    = wr ? 32'h0 : mem_model[a[3:2]];
    eresp = resp_of(a);
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_rdata", rsp_rdata, er);
    check("rsp_resp", rsp_resp, eresp);
    check("rsp_timeout", rsp_timeout, 1'b0);
    check("cmd_ready_in_rsp", cmd_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_rdata", rsp_rdata, er);
      check("hold_resp", rsp_resp, eresp);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_model[a[3:2]][8*b +: 8] = d[8*b +: 8];
      n_wr++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, bc;
    for (int i = 0; i < 4; i++) begin mem_model[i] = '0; mem_slv[i] = '0; end
    areset = 1;
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}, 7'h0);
    check("rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    check("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 44'h0);
    areset = 0;
    @(negedge aclk);

    // Minimum-latency write.
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    run_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF, 0);
    check("t1_latency", last_lat, 3);
    check("t1_awv_wv_c1", {awv1, wv1}, 2'b11);

    // W accepted three cycles before AW.
    bc = b_cnt;
    aw_dly = 3; w_dly = 0;
    run_cmd(1, 4'h4, 32'hA5A5_0F0F, 4'hF, 0);
    check("t2_c1", {awv1, wv1}, 2'b11);
    check("t2_c2", {awv2, wv2}, 2'b10);
    check("t2_one_b", b_cnt - bc, 1);
    aw_dly = 0;

    // Read with slow R and SLVERR passthrough.
    run_cmd(1, 4'h8, 32'h12345678, 4'hF, 0);
    r_dly = 5;
    run_cmd(0, 4'h8, 32'h0, 4'h0, 0);
    check("t3_rdata", rsp_rdata, 32'h12345678);
    check("t3_arv_c1", arv1, 1'b1);
    r_dly = 0;
    run_cmd(0, 4'h0, 32'h0, 4'h0, 0);
    check("t3_min_read_latency", last_lat, 3);

    // Response back-pressure for 10 cycles.
    run_cmd(0, 4'h4, 32'h0, 4'h0, 10);

    // Reset while waiting for B.
    b_dly = 20;
    exp_addr = 4'hC; exp_wdata = 32'hCAFEF00D; exp_wstrb = 4'hF;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    cmd_valid = 0;
    n = 0;
    while (!bready && n < 20) begin @(negedge aclk); n++; end
    check("t5_in_wr_b", bready, 1'b1);
    #2 areset = 1;
    #1;
    check("t5_rst_cmd_ready", cmd_ready, 1'b1);
    check("t5_rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}, 7'h0);
    check("t5_rst_addr_data", {awaddr, araddr, wdata, wstrb}, 44'h0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 0;
    b_dly = 0;
    @(negedge aclk);
    run_cmd(0, 4'hC, 32'h0, 4'h0, 0);
    run_cmd(1, 4'hC, 32'h0BAD_F00D, 4'h3, 1);
    run_cmd(0, 4'hC, 32'h0, 4'h0, 0);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    // Slave never accepts AR: watchdog aborts after 16 cycles.
    never_arready = 1; tmo_mode = 1;
    exp_addr = 4'h0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    cmd_valid = 0;
    n = 0;
    while (arvalid && n < 100) begin @(negedge aclk); n++; end
    check("t6_arvalid_cycles", n, 16);
    check("t6_rsp_valid", rsp_valid, 1'b1);
    check("t6_rsp_resp", rsp_resp, 2'b10);
    check("t6_rsp_timeout", rsp_timeout, 1'b1);
    check("t6_rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    never_arready = 0; tmo_mode = 0;
    @(negedge aclk);
`endif

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    check("protocol_valid_drops", viol, 0);
    check("b_count", b_cnt, n_wr);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
